// File: rtl/move_scheduler.sv
// Debounces four direction buttons and issues frame-aligned one-clock move pulses with a step value.
// Optional auto-bounce source is compiled in when AUTO_BOUNCE_EN is defined.
module move_scheduler #(
    parameter int DEBOUNCE_W = 16,
    parameter int FRAME_DIV  = 8,
    parameter int BOUNCE_LEN = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frameTick,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       btnLeft,
    input  logic       btnRight,
    input  logic [3:0] stepIn,
    input  logic       autoMode,
    output logic [3:0] moveDirection,
    output logic [3:0] moveStep,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, ARMED, HOLD, AUTO} state_t;

    localparam logic [7:0] REP_RELOAD = 8'(FRAME_DIV - 1);

    state_t state, nextState;

    logic [3:0] rawBtn, syncA, syncB, btnState;
    logic [DEBOUNCE_W-1:0] dbCnt [4];
    logic [3:0] dirReq, stepClamp;

    logic [3:0] pending, latchedStep, lastDir, emitDir;
    logic [7:0] repCnt;
    logic       latchReq, emit, repLoad, repDec;

    assign rawBtn    = {btnRight, btnLeft, btnDown, btnUp};
    assign stepClamp = (stepIn == 4'd0) ? 4'd1 : stepIn;
    assign busy      = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            syncA <= 4'b0000;
            syncB <= 4'b0000;
        end else begin
            syncA <= rawBtn;
            syncB <= syncA;
        end
    end

    // NOTE: the per-button counters are a handful of flops, not a RAM, so they are reset like any register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btnState <= 4'b0000;
            for (int i = 0; i < 4; i++) dbCnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (syncB[i] == btnState[i]) begin
                    dbCnt[i] <= '0;
                end else if (dbCnt[i] == '1) begin
                    dbCnt[i]    <= '0;
                    btnState[i] <= syncB[i];
                end else begin
                    dbCnt[i] <= dbCnt[i] + 1'b1;
                end
            end
        end
    end

    // Opposing buttons on one axis cancel that axis only, so diagonals survive.
    always_comb begin
        dirReq = btnState;
        if (btnState[0] && btnState[1]) dirReq[1:0] = 2'b00;
        if (btnState[2] && btnState[3]) dirReq[3:2] = 2'b00;
    end

`ifdef AUTO_BOUNCE_EN
    localparam logic [7:0] BOUNCE_TOP = 8'(BOUNCE_LEN);

    logic [3:0] autoDir;
    logic [7:0] autoCnt, bounceCnt;
    logic       autoLoad, autoDec, emitAuto;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            autoDir   <= 4'b1010;
            autoCnt   <= 8'd0;
            bounceCnt <= 8'd0;
        end else begin
            if (autoLoad) autoCnt <= REP_RELOAD;
            else if (autoDec) autoCnt <= autoCnt - 8'd1;
            if (emitAuto) begin
                if (bounceCnt + 8'd1 == BOUNCE_TOP) begin
                    bounceCnt <= 8'd0;
                    autoDir   <= ~autoDir;
                end else begin
                    bounceCnt <= bounceCnt + 8'd1;
                end
            end
        end
    end
`else
    logic unusedAutoMode;
    assign unusedAutoMode = autoMode | (BOUNCE_LEN < 1);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        nextState = state;
        latchReq  = 1'b0;
        emit      = 1'b0;
        emitDir   = 4'b0000;
        repLoad   = 1'b0;
        repDec    = 1'b0;
`ifdef AUTO_BOUNCE_EN
        autoLoad  = 1'b0;
        autoDec   = 1'b0;
        emitAuto  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (dirReq != 4'b0000) begin
                    nextState = ARMED;
                    latchReq  = 1'b1;
                end
`ifdef AUTO_BOUNCE_EN
                else if (autoMode) begin
                    nextState = AUTO;
                    autoLoad  = 1'b1;
                end
`endif
            end
            ARMED: begin
                if (frameTick) begin
                    nextState = HOLD;
                    emit      = 1'b1;
                    emitDir   = pending;
                    repLoad   = 1'b1;
                end
            end
            HOLD: begin
                if (dirReq == 4'b0000) begin
                    nextState = IDLE;
                end else if (dirReq != lastDir) begin
                    nextState = ARMED;
                    latchReq  = 1'b1;
                end else if (frameTick) begin
                    if (repCnt == 8'd0) begin
                        emit    = 1'b1;
                        emitDir = dirReq;
                        repLoad = 1'b1;
                    end else begin
                        repDec = 1'b1;
                    end
                end
            end
`ifdef AUTO_BOUNCE_EN
            AUTO: begin
                if (dirReq != 4'b0000) begin
                    nextState = ARMED;
                    latchReq  = 1'b1;
                end else if (!autoMode) begin
                    nextState = IDLE;
                end else if (frameTick) begin
                    if (autoCnt == 8'd0) begin
                        emitAuto = 1'b1;
                        autoLoad = 1'b1;
                    end else begin
                        autoDec = 1'b1;
                    end
                end
            end
`endif
            default: nextState = IDLE;
        endcase
    end

    // moveDirection falls back to zero every clock, which makes each emit a single-clock pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending       <= 4'b0000;
            latchedStep   <= 4'd1;
            lastDir       <= 4'b0000;
            repCnt        <= 8'd0;
            moveDirection <= 4'b0000;
            moveStep      <= 4'd1;
        end else begin
            moveDirection <= 4'b0000;
            if (latchReq) begin
                pending     <= dirReq;
                latchedStep <= stepClamp;
            end
            if (emit) begin
                moveDirection <= emitDir;
                moveStep      <= latchedStep;
                lastDir       <= emitDir;
            end
`ifdef AUTO_BOUNCE_EN
            if (emitAuto) begin
                moveDirection <= autoDir;
                moveStep      <= 4'd1;
            end
`endif
            if (repLoad) repCnt <= REP_RELOAD;
            else if (repDec) repCnt <= repCnt - 8'd1;
        end
    end

endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: directed scenarios plus random frames against a frame-level model.
module tb_move_scheduler;

    localparam int DW = 2;
    localparam int FD = 3;
    localparam int BL = 2;
`ifdef AUTO_BOUNCE_EN
    localparam bit AUTO_ON = 1'b1;
`else
    localparam bit AUTO_ON = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       frameTick;
    logic       btnUp, btnDown, btnLeft, btnRight;
    logic [3:0] stepIn;
    logic       autoMode;
    logic [3:0] moveDirection, moveStep;
    logic       busy;

    move_scheduler #(.DEBOUNCE_W(DW), .FRAME_DIV(FD), .BOUNCE_LEN(BL)) dut (
        .clock(clock), .reset(reset), .frameTick(frameTick),
        .btnUp(btnUp), .btnDown(btnDown), .btnLeft(btnLeft), .btnRight(btnRight),
        .stepIn(stepIn), .autoMode(autoMode),
        .moveDirection(moveDirection), .moveStep(moveStep), .busy(busy)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int stepNo = 0;

    logic [3:0] curBtn;
    logic [3:0] lastPulse, lastStep;

    // Frame-level reference: what the sequencer is doing between frames, not how it is built.
    typedef enum {M_IDLE, M_WAIT, M_REPEAT, M_AUTO} mode_e;
    mode_e      mMode;
    logic [3:0] mPend, mLast, mStepReq, mStepOut, mAutoDir;
    int         mFramesLeft, mAutoWait, mAutoCount;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s (step %0d): observed=%h expected=%h", tag, stepNo, observed, expected);
        end
    endtask

    function automatic logic [3:0] req_of(input logic [3:0] b);
        logic [3:0] r;
        r = b;
        if (b[0] && b[1]) r[1:0] = 2'b00;
        if (b[2] && b[3]) r[3:2] = 2'b00;
        return r;
    endfunction

    task automatic set_btn(input logic [3:0] b);
        {btnRight, btnLeft, btnDown, btnUp} = b;
        curBtn = b;
    endtask

    task automatic model_reset();
        mMode = M_IDLE; mPend = 4'b0; mLast = 4'b0; mStepReq = 4'd1; mStepOut = 4'd1;
        mAutoDir = 4'b1010; mFramesLeft = 0; mAutoWait = 0; mAutoCount = 0;
    endtask

    task automatic model_take(input logic [3:0] r);
        mMode    = M_WAIT;
        mPend    = r;
        mStepReq = (stepIn == 4'd0) ? 4'd1 : stepIn;
    endtask

    // Apply a settled, debounced request level to the model.
    task automatic model_level(input logic [3:0] r);
        for (int pass = 0; pass < 2; pass++) begin
            case (mMode)
                M_IDLE:   if (r != 4'b0) model_take(r);
                          else if (AUTO_ON && autoMode) begin mMode = M_AUTO; mAutoWait = FD - 1; end
                M_REPEAT: if (r == 4'b0) mMode = M_IDLE;
                          else if (r != mLast) model_take(r);
                M_AUTO:   if (r != 4'b0) model_take(r);
                          else if (!autoMode) mMode = M_IDLE;
                default:  ;
            endcase
        end
    endtask

    task automatic model_tick(output logic [3:0] expDir);
        expDir = 4'b0000;
        case (mMode)
            M_WAIT: begin
                expDir = mPend; mStepOut = mStepReq; mLast = mPend;
                mMode = M_REPEAT; mFramesLeft = FD - 1;
            end
            M_REPEAT: begin
                if (mFramesLeft == 0) begin
                    expDir = mLast; mStepOut = mStepReq; mFramesLeft = FD - 1;
                end else mFramesLeft--;
            end
            M_AUTO: begin
                if (mAutoWait == 0) begin
                    expDir = mAutoDir; mStepOut = 4'd1; mAutoCount++;
                    if (mAutoCount == BL) begin mAutoDir = ~mAutoDir; mAutoCount = 0; end
                    mAutoWait = FD - 1;
                end else mAutoWait--;
            end
            default: ;
        endcase
    endtask

    task automatic do_tick();
        logic [3:0] expDir;
        frameTick = 1'b1;
        @(negedge clock);
        frameTick = 1'b0;
        model_tick(expDir);
        lastPulse = moveDirection;
        lastStep  = moveStep;
        check("pulse_dir", {12'b0, moveDirection}, {12'b0, expDir});
        check("pulse_step", {12'b0, moveStep}, {12'b0, mStepOut});
        check("pulse_busy", {15'b0, busy}, {15'b0, mMode != M_IDLE});
        model_level(req_of(curBtn));
        @(negedge clock);
        check("pulse_width", {12'b0, moveDirection}, 16'h0000);
    endtask

    // One frame: settle inputs (optionally via a short tap), then a frame tick.
    task automatic frame_step(input logic [3:0] hold, input logic [3:0] tap, input bit doTap,
                              input logic [3:0] step, input logic am);
        stepNo++;
        autoMode = am;
        model_level(req_of(curBtn));
        stepIn = step;
        if (doTap) begin
            set_btn(tap);
            repeat (10) @(negedge clock);
            model_level(req_of(tap));
        end
        set_btn(hold);
        repeat (16) @(negedge clock);
        model_level(req_of(hold));
        check("idle_dir", {12'b0, moveDirection}, 16'h0000);
        check("pre_busy", {15'b0, busy}, {15'b0, mMode != M_IDLE});
        do_tick();
    endtask

    initial begin
        logic [15:0] pulsed;
        logic [3:0]  h, t, s;
        logic        am;
        bit          tp;

        reset = 1'b1; frameTick = 1'b0; stepIn = 4'd1; autoMode = 1'b0;
        set_btn(4'b0000);
        model_reset();
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_dir", {12'b0, moveDirection}, 16'h0000);
        check("rst_step", {12'b0, moveStep}, 16'h0001);
        check("rst_busy", {15'b0, busy}, 16'h0000);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Tap Up with step 5: one pulse, then back to idle.
        frame_step(4'b0000, 4'b0001, 1'b1, 4'd5, 1'b0);
        check("tap_const_dir", {12'b0, lastPulse}, 16'h0001);
        check("tap_const_step", {12'b0, lastStep}, 16'h0005);
        repeat (3) @(negedge clock);
        check("tap_busy_fall", {15'b0, busy}, 16'h0000);

        // Zero step is clamped to one.
        frame_step(4'b0000, 4'b0010, 1'b1, 4'd0, 1'b0);
        check("zero_step_dir", {12'b0, lastPulse}, 16'h0002);
        check("zero_step_val", {12'b0, lastStep}, 16'h0001);

        // Hold Right across 10 ticks: pulses after ticks 1, 4, 7, 10.
        pulsed = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            frame_step(4'b1000, 4'b0000, 1'b0, 4'd3, 1'b0);
            if (lastPulse == 4'b1000) pulsed[i] = 1'b1;
        end
        check("hold_pattern", pulsed, 16'b0000_0010_0100_1001);

        // Up+Down+Left: vertical cancels; Up+Down alone: nothing at all.
        frame_step(4'b0111, 4'b0000, 1'b0, 4'd2, 1'b0);
        check("conflict_ul", {12'b0, lastPulse}, 16'h0004);
        frame_step(4'b0111, 4'b0000, 1'b0, 4'd2, 1'b0);
        frame_step(4'b0011, 4'b0000, 1'b0, 4'd2, 1'b0);
        frame_step(4'b0011, 4'b0000, 1'b0, 4'd2, 1'b0);
        check("conflict_ud_none", {12'b0, lastPulse}, 16'h0000);
        check("conflict_ud_busy", {15'b0, busy}, 16'h0000);
        frame_step(4'b0000, 4'b0000, 1'b0, 4'd2, 1'b0);

        // Async reset during a hold-repeat pulse clock.
        for (int i = 0; i < 3; i++) frame_step(4'b1000, 4'b0000, 1'b0, 4'd7, 1'b0);
        stepNo++;
        frameTick = 1'b1;
        @(negedge clock);
        frameTick = 1'b0;
        model_tick(t);
        check("arst_pre_model", {12'b0, moveDirection}, {12'b0, t});
        check("arst_pre_const", {12'b0, moveDirection}, 16'h0008);
        reset = 1'b0;
        #1;
        check("arst_dir", {12'b0, moveDirection}, 16'h0000);
        check("arst_step", {12'b0, moveStep}, 16'h0001);
        check("arst_busy", {15'b0, busy}, 16'h0000);
        set_btn(4'b0000);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        model_reset();
        frame_step(4'b0000, 4'b0000, 1'b0, 4'd7, 1'b0);
        check("arst_no_pulse", {12'b0, lastPulse}, 16'h0000);

`ifdef AUTO_BOUNCE_EN
        // Auto-bounce with no buttons, then Left takes over.
        for (int i = 0; i < 8; i++) frame_step(4'b0000, 4'b0000, 1'b0, 4'd4, 1'b1);
        frame_step(4'b0010, 4'b0000, 1'b0, 4'd4, 1'b1);
        frame_step(4'b0100, 4'b0000, 1'b0, 4'd4, 1'b1);
        check("auto_left_wins", {12'b0, lastPulse}, 16'h0004);
        frame_step(4'b0000, 4'b0000, 1'b0, 4'd4, 1'b0);
`else
        // autoMode is ignored in this build.
        for (int i = 0; i < 3; i++) frame_step(4'b0000, 4'b0000, 1'b0, 4'd4, 1'b1);
        check("auto_ignored_busy", {15'b0, busy}, 16'h0000);
        check("auto_ignored_dir", {12'b0, lastPulse}, 16'h0000);
        autoMode = 1'b0;
`endif

        // Random frames.
        am = 1'b0;
        for (int i = 0; i < 120; i++) begin
            h  = ($urandom_range(2) == 0) ? 4'($urandom_range(15)) : curBtn;
            t  = 4'($urandom_range(15));
            tp = ($urandom_range(3) == 0);
            s  = 4'($urandom_range(15));
            if ($urandom_range(7) == 0) am = ~am;
            frame_step(h, t, tp, s, am);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
